bingo_board_ctrl: RTL and testbench
===================================

Name: bingo_board_ctrl

Overview:
- Owns the 5x5 bingo board consumed by the per-block display window: fills it, optionally shuffles it, services "mark number" requests, and scores completed lines.
- Drives the packed `map` bus read by the display path. A marked cell reads 0, which the display renders as background.
- Sits between game/input logic and display; runs on the pixel clock.

Parameters:
- WIN_LINES, 5, completed lines (rows + columns + diagonals) needed to win; legal 1..12.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk_25MHz  in  1  system/pixel clock
- all_rst  in  1  reset; synchronous, active-high
- start  in  1  new-game request, level-sampled
- mark_valid  in  1  mark request valid
- mark_num  in  5  number to mark
- mark_ready  out  1  request accepted when mark_valid && mark_ready
- mark_done  out  1  one-cycle pulse; result valid
- mark_hit  out  1  valid with mark_done; 1 = number found and cleared
- map  out  125  cell i (i = x + 5*y, row-major) at bits [5i+4:5i]; 0 = empty/marked
- line_cnt  out  4  completed lines, 0..12
- win  out  1  line_cnt >= WIN_LINES

Behaviour:
- Reset (next edge with all_rst=1, from any state, including mid-FILL/SHUFFLE/SEARCH):
  - state IDLE, all cells 0, LFSR=LFSR_SEED.
  - mark_ready, mark_done, mark_hit, win, line_cnt all 0.
- LFSR: 16-bit Galois, taps 16,14,13,11. Steps every non-reset cycle in every state.
- IDLE:
  - start -> FILL; line_cnt and win cleared.
  - mark_valid ignored.
- FILL: idx 0..24, one cell per cycle, cell[idx] = idx+1 (25 cycles). Then SHUFFLE, or PLAY if shuffle is compiled out.
- SHUFFLE: i = 24 down to 1, one swap per cycle (24 cycles).
  - j = (lfsr[7:0] * (i+1)) >> 8, so 0 <= j <= i.
  - Swap cell[i] and cell[j] in the same edge; j == i is a no-op.
  - Then PLAY.
- PLAY:
  - mark_ready=1.
  - On accept: latch mark_num, drop mark_ready, go to SEARCH idx=0.
  - start takes priority over mark_valid -> FILL.
- SEARCH: one cell per cycle.
  - cell[idx] == num and num != 0: clear cell to 0, hit=1, go SCORE.
  - idx == 24 with no match: hit=0, go SCORE.
  - num 0 or >25 never matches, i.e. a miss.
  - An already-marked number is a miss; map unchanged.
- SCORE (1 cycle):
  - Zero-mask of all cells -> line count over 5 rows, 5 columns, 2 diagonals; register line_cnt.
  - Pulse mark_done with mark_hit.
  - line_cnt >= WIN_LINES -> DONE, win=1; else PLAY.
- Latency, with the accept cycle as c0:
  - Hit at index k: SCORE in c(2+k); mark_done, line_cnt and mark_ready visible in c(3+k).
  - Miss: mark_done visible in c27.
  - start in c0 (IDLE): FILL c1..c25, PLAY/mark_ready c26; with shuffle, SHUFFLE c26..c49, PLAY c50.
- DONE:
  - map, line_cnt and win held; mark_ready=0.
  - start -> FILL, clearing win and line_cnt.
- start is ignored in FILL, SHUFFLE, SEARCH and SCORE.
- map is driven from registers: no glitches, stable except on fill/swap/clear edges.

Optional Feature:
- BINGO_SHUFFLE_EN defined: SHUFFLE state present; board is an LFSR-driven permutation of 1..25.
- Undefined: FILL goes straight to PLAY; board is identity (cell i = i+1); the LFSR may be removed.

Decomposition:
- Package bingo_pkg:
  - BOARD_DIM=5, CELLS=25, NUM_W=5, LINE_CNT_W=4.
  - State enum {IDLE, FILL, SHUFFLE, PLAY, SEARCH, SCORE, DONE}.
  - LFSR tap constant.
- Sub-module bingo_line_counter: combinational; 25-bit marked mask in, 4-bit count out (12 line ANDs, popcount). Reused by any future second-player board.

Test Plan:
- Macro off; reset; start at c0 -> map == {25..1} packed (cell0=1, cell24=25); mark_ready rises in c26; win=0, line_cnt=0.
- Mark 13 accepted at c0 -> c15: mark_done=1, mark_hit=1, cell12=0, line_cnt=0, mark_ready=1.
- Mark 1,7,13,19,25 -> after the fifth, line_cnt=1 (diagonal). Then re-mark 13, mark 0 and 26 -> each mark_hit=0, done 27 cycles after accept, map unchanged.
- WIN_LINES=1; mark 1..5 -> line_cnt=1, win=1, mark_ready=0 held. start -> map refilled 1..25, win=0, line_cnt=0, mark_ready at +26.
- all_rst asserted during SEARCH (idx=10) -> next cycle map all zero, all outputs 0, start required to resume; mark_done never pulses.
- Macro on; start -> mark_ready at c50; map holds each of 1..25 exactly once. Two runs with different start timing give different boards.

Source files
------------

// File: rtl/bingo_pkg.sv
// Shared definitions for the bingo board controller: board geometry,
// controller states and the LFSR feedback constant.
package bingo_pkg;

    localparam int BOARD_DIM  = 5;
    localparam int CELLS      = 25;
    localparam int NUM_W      = 5;
    localparam int LINE_CNT_W = 4;
    localparam int LINES      = 12;  // 5 rows + 5 columns + 2 diagonals

    // Right-shifting Galois LFSR, taps at 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHUFFLE,
        PLAY,
        SEARCH,
        SCORE,
        DONE
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/bingo_line_counter.sv
// Counts completed bingo lines (5 rows, 5 columns, 2 diagonals) from a
// mask of marked cells. Purely combinational so a second board can reuse it.
module bingo_line_counter
    import bingo_pkg::*;
(
    input  logic [CELLS-1:0]      marked_i,
    output logic [LINE_CNT_W-1:0] count_o
);

    logic [LINES-1:0] lines;

    // One AND per line, then a popcount over the twelve line flags.
    always_comb begin
        lines = '0;
        for (int y = 0; y < BOARD_DIM; y++) begin
            lines[y] = &marked_i[y*BOARD_DIM +: BOARD_DIM];
        end
        for (int x = 0; x < BOARD_DIM; x++) begin
            lines[BOARD_DIM + x] = marked_i[x] & marked_i[x + 5] & marked_i[x + 10]
                                 & marked_i[x + 15] & marked_i[x + 20];
        end
        lines[10] = marked_i[0] & marked_i[6] & marked_i[12] & marked_i[18] & marked_i[24];
        lines[11] = marked_i[4] & marked_i[8] & marked_i[12] & marked_i[16] & marked_i[20];

        count_o = '0;
        for (int k = 0; k < LINES; k++) begin
            count_o = count_o + {{(LINE_CNT_W-1){1'b0}}, lines[k]};
        end
    end

endmodule

// File: rtl/bingo_board_ctrl.sv
// Bingo board controller: fills the 5x5 board, optionally shuffles it,
// services mark requests one cell per cycle and scores completed lines.
// Optional shuffle is compiled in with `define BINGO_SHUFFLE_EN.
// Mark handshake: a request transfers on the edge where mark_valid and
// mark_ready are both high; mark_num must be stable while mark_valid is high,
// and the result comes back later as a one-cycle mark_done pulse.
module bingo_board_ctrl
    import bingo_pkg::*;
#(
    parameter int          WIN_LINES = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                        clk_25MHz,
    input  logic                        all_rst,
    input  logic                        start,
    input  logic                        mark_valid,
    input  logic [NUM_W-1:0]            mark_num,
    output logic                        mark_ready,
    output logic                        mark_done,
    output logic                        mark_hit,
    output logic [CELLS*NUM_W-1:0]      map,
    output logic [LINE_CNT_W-1:0]       line_cnt,
    output logic                        win
);

    localparam logic [4:0]            LAST_IDX  = 5'(CELLS - 1);
    localparam logic [LINE_CNT_W-1:0] WIN_LIM   = LINE_CNT_W'(WIN_LINES);

    state_e                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [NUM_W-1:0]      num_q, num_d;
    logic [NUM_W-1:0]      cell_q [CELLS];
    logic [NUM_W-1:0]      cell_d [CELLS];
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  win_q, win_d;
    logic                  found_q, found_d;
    logic                  done_q, done_d;
    logic                  hit_q, hit_d;

    logic [CELLS-1:0]      marked;
    logic [LINE_CNT_W-1:0] line_cnt_now;

`ifdef BINGO_SHUFFLE_EN
    logic [15:0] lfsr_q;
    logic [12:0] shuf_prod;
    logic [4:0]  shuf_j;

    // Free-running LFSR; its phase at SHUFFLE depends on when start arrived.
    always_ff @(posedge clk_25MHz) begin
        if (all_rst) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_next(lfsr_q);
    end

    // Scale an 8-bit random value into 0..idx for the current swap.
    always_comb begin
        shuf_prod = {5'd0, lfsr_q[7:0]} * {8'd0, idx_q + 5'd1};
        shuf_j    = 5'(shuf_prod >> 8);
    end
`else
    // Without the shuffle the seed has no consumer.
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
`endif

    // Zero-mask of the board feeds the line scorer.
    always_comb begin
        marked = '0;
        for (int i = 0; i < CELLS; i++) marked[i] = (cell_q[i] == '0);
    end

    bingo_line_counter u_line_counter (
        .marked_i (marked),
        .count_o  (line_cnt_now)
    );

    // Next-state logic for the board FSM, cells and result flags.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        cell_d     = cell_q;
        line_cnt_d = line_cnt_q;
        win_d      = win_q;
        found_d    = found_q;
        done_d     = 1'b0;
        hit_d      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = FILL;
                    idx_d      = '0;
                    line_cnt_d = '0;
                    win_d      = 1'b0;
                end
            end
            FILL: begin
                cell_d[idx_q] = idx_q + 5'd1;
                if (idx_q == LAST_IDX) begin
`ifdef BINGO_SHUFFLE_EN
                    state_d = SHUFFLE;
                    idx_d   = LAST_IDX;
`else
                    state_d = PLAY;
`endif
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            SHUFFLE: begin
`ifdef BINGO_SHUFFLE_EN
                cell_d[idx_q]  = cell_q[shuf_j];
                cell_d[shuf_j] = cell_q[idx_q];
                if (idx_q == 5'd1) state_d = PLAY;
                else               idx_d   = idx_q - 5'd1;
`else
                state_d = PLAY;
`endif
            end
            PLAY: begin
                // A new game wins over a pending mark request.
                if (start) begin
                    state_d    = FILL;
                    idx_d      = '0;
                    line_cnt_d = '0;
                    win_d      = 1'b0;
                end else if (mark_valid) begin
                    state_d = SEARCH;
                    num_d   = mark_num;
                    idx_d   = '0;
                end
            end
            SEARCH: begin
                // Cleared cells hold 0, so number 0 must never count as found.
                if ((num_q != '0) && (cell_q[idx_q] == num_q)) begin
                    cell_d[idx_q] = '0;
                    found_d       = 1'b1;
                    state_d       = SCORE;
                end else if (idx_q == LAST_IDX) begin
                    found_d = 1'b0;
                    state_d = SCORE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            SCORE: begin
                done_d     = 1'b1;
                hit_d      = found_q;
                line_cnt_d = line_cnt_now;
                if (line_cnt_now >= WIN_LIM) begin
                    state_d = DONE;
                    win_d   = 1'b1;
                end else begin
                    state_d = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and board registers with synchronous reset.
    always_ff @(posedge clk_25MHz) begin
        if (all_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            line_cnt_q <= '0;
            win_q      <= 1'b0;
            found_q    <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            for (int i = 0; i < CELLS; i++) cell_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            line_cnt_q <= line_cnt_d;
            win_q      <= win_d;
            found_q    <= found_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            for (int i = 0; i < CELLS; i++) cell_q[i] <= cell_d[i];
        end
    end

    // Pack the registered cells row-major onto the display bus.
    always_comb begin
        map = '0;
        for (int i = 0; i < CELLS; i++) map[i*NUM_W +: NUM_W] = cell_q[i];
    end

    assign mark_ready = (state_q == PLAY);
    assign mark_done  = done_q;
    assign mark_hit   = hit_q;
    assign line_cnt   = line_cnt_q;
    assign win        = win_q;

endmodule

// File: tb/tb_bingo_board_ctrl.sv
// Directed bench for bingo_board_ctrl: one board with the default win
// threshold and one with WIN_LINES=1, driven from shared inputs.
module tb_bingo_board_ctrl;

    logic         clk_25MHz = 1'b0;
    logic         all_rst, start, mark_valid;
    logic [4:0]   mark_num;
    logic         ready0, done0, hit0, win0, ready1, done1, hit1, win1;
    logic [124:0] map0, map1;
    logic [3:0]   lc0, lc1;

    int errors = 0;
    int checks = 0;

    logic [4:0] model [25];

    typedef struct {
        logic [4:0] num;
        logic       exp_hit;
        int         exp_lat;
        logic [3:0] exp_lc;
    } mark_vec_t;

    mark_vec_t tbl [8];

    always #5 clk_25MHz = ~clk_25MHz;

    bingo_board_ctrl dut (
        .clk_25MHz (clk_25MHz), .all_rst (all_rst), .start (start),
        .mark_valid (mark_valid), .mark_num (mark_num),
        .mark_ready (ready0), .mark_done (done0), .mark_hit (hit0),
        .map (map0), .line_cnt (lc0), .win (win0)
    );

    bingo_board_ctrl #(.WIN_LINES(1)) dut1 (
        .clk_25MHz (clk_25MHz), .all_rst (all_rst), .start (start),
        .mark_valid (mark_valid), .mark_num (mark_num),
        .mark_ready (ready1), .mark_done (done1), .mark_hit (hit1),
        .map (map1), .line_cnt (lc1), .win (win1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [124:0] pack_model();
        logic [124:0] m;
        m = '0;
        for (int i = 0; i < 25; i++) m[i*5 +: 5] = model[i];
        return m;
    endfunction

    function automatic logic [124:0] identity_map();
        logic [124:0] m;
        m = '0;
        for (int i = 0; i < 25; i++) m[i*5 +: 5] = 5'(i + 1);
        return m;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 25; i++) model[i] = 5'(i + 1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_25MHz);
        all_rst = 1'b1;
        repeat (cycles) @(negedge clk_25MHz);
        all_rst = 1'b0;
    endtask

    // Pulse start for one cycle; return the cycle index at which dut's
    // mark_ready is first seen (start cycle is c0), or -1 on timeout.
    task automatic do_start(output int lat);
        @(negedge clk_25MHz);
        start = 1'b1;
        @(posedge clk_25MHz);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk_25MHz);
            if (ready0) begin
                lat = c;
                break;
            end
        end
    endtask

    // Issue one mark on dut; return cycle of mark_done (accept = c0) and hit.
    task automatic do_mark(input logic [4:0] n, output int lat, output logic hit);
        int waited;
        waited = 0;
        lat = -1;
        hit = 1'bx;
        @(negedge clk_25MHz);
        while (!ready0 && waited < 100) begin
            @(negedge clk_25MHz);
            waited++;
        end
        if (!ready0) begin
            chk("mark_ready_timeout", 128'(ready0), 128'(1));
            return;
        end
        mark_valid = 1'b1;
        mark_num   = n;
        @(posedge clk_25MHz);
        #1 mark_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_25MHz);
            if (done0) begin
                lat = c;
                hit = hit0;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic       hit;
        logic [124:0] board_a;
        bit         seen_done, seen_ready;

        all_rst    = 1'b1;
        start      = 1'b0;
        mark_valid = 1'b0;
        mark_num   = '0;

        tbl[0] = '{num: 5'd13, exp_hit: 1'b1, exp_lat: 15, exp_lc: 4'd0};
        tbl[1] = '{num: 5'd1,  exp_hit: 1'b1, exp_lat: 3,  exp_lc: 4'd0};
        tbl[2] = '{num: 5'd7,  exp_hit: 1'b1, exp_lat: 9,  exp_lc: 4'd0};
        tbl[3] = '{num: 5'd19, exp_hit: 1'b1, exp_lat: 21, exp_lc: 4'd0};
        tbl[4] = '{num: 5'd25, exp_hit: 1'b1, exp_lat: 27, exp_lc: 4'd1};
        tbl[5] = '{num: 5'd13, exp_hit: 1'b0, exp_lat: 27, exp_lc: 4'd1};
        tbl[6] = '{num: 5'd0,  exp_hit: 1'b0, exp_lat: 27, exp_lc: 4'd1};
        tbl[7] = '{num: 5'd26, exp_hit: 1'b0, exp_lat: 27, exp_lc: 4'd1};

        // Reset state.
        do_reset(3);
        chk("rst_map", 128'(map0), 128'(0));
        chk("rst_outs", 128'({ready0, done0, hit0, win0, lc0}), 128'(0));

`ifdef BINGO_SHUFFLE_EN
        // Shuffled board: ready at c50, permutation of 1..25, timing-dependent.
        do_start(lat);
        chk("shuf_ready_lat", 128'(lat), 128'(50));
        begin
            int cnt [26];
            bit ok;
            ok = 1'b1;
            for (int v = 0; v < 26; v++) cnt[v] = 0;
            for (int i = 0; i < 25; i++) cnt[map0[i*5 +: 5]]++;
            for (int v = 1; v <= 25; v++) if (cnt[v] != 1) ok = 1'b0;
            chk("shuf_perm_a", 128'(ok), 128'(1));
        end
        board_a = map0;
        do_reset(1);
        repeat (7) @(negedge clk_25MHz);
        do_start(lat);
        chk("shuf_ready_lat_b", 128'(lat), 128'(50));
        begin
            int cnt [26];
            bit ok;
            ok = 1'b1;
            for (int v = 0; v < 26; v++) cnt[v] = 0;
            for (int i = 0; i < 25; i++) cnt[map0[i*5 +: 5]]++;
            for (int v = 1; v <= 25; v++) if (cnt[v] != 1) ok = 1'b0;
            chk("shuf_perm_b", 128'(ok), 128'(1));
        end
        chk("shuf_boards_differ", 128'(board_a != map0), 128'(1));
        chk("shuf_win", 128'({win0, lc0}), 128'(0));
`else
        board_a = '0;
        // Fill: identity board, ready at c26.
        do_start(lat);
        chk("fill_ready_lat", 128'(lat), 128'(26));
        chk("fill_map", 128'(map0), 128'(identity_map()));
        chk("fill_win_lc", 128'({win0, lc0}), 128'(0));
        reset_model();

        // Mark table: hits, diagonal completion, repeat and out-of-range misses.
        for (int i = 0; i < 8; i++) begin
            do_mark(tbl[i].num, lat, hit);
            chk($sformatf("mark%0d_lat", i), 128'(lat), 128'(tbl[i].exp_lat));
            chk($sformatf("mark%0d_hit", i), 128'(hit), 128'(tbl[i].exp_hit));
            chk($sformatf("mark%0d_lc", i), 128'(lc0), 128'(tbl[i].exp_lc));
            if (tbl[i].exp_hit) model[tbl[i].num - 5'd1] = 5'd0;
            chk($sformatf("mark%0d_map", i), 128'(map0), 128'(pack_model()));
            chk($sformatf("mark%0d_ready", i), 128'(ready0), 128'(1));
        end
        chk("dut_no_win", 128'(win0), 128'(0));
        // The WIN_LINES=1 board saw the same diagonal and must have won.
        chk("dut1_diag_win", 128'({win1, lc1, ready1}), 128'({1'b1, 4'd1, 1'b0}));

        // New game from DONE and PLAY: refill, scores cleared.
        do_start(lat);
        chk("restart_lat", 128'(lat), 128'(26));
        chk("restart_dut1_ready", 128'(ready1), 128'(1));
        chk("restart_dut1_map", 128'(map1), 128'(identity_map()));
        chk("restart_dut1_win_lc", 128'({win1, lc1}), 128'(0));
        reset_model();

        // Row 0 completion wins on the WIN_LINES=1 board.
        for (int n = 1; n <= 5; n++) begin
            do_mark(5'(n), lat, hit);
            chk($sformatf("row_mark%0d_lat", n), 128'(lat), 128'(n + 2));
            model[n-1] = 5'd0;
        end
        chk("row_dut1_win", 128'({win1, lc1, ready1}), 128'({1'b1, 4'd1, 1'b0}));
        chk("row_dut_lc", 128'({win0, lc0}), 128'({1'b0, 4'd1}));
        repeat (5) @(negedge clk_25MHz);
        chk("done_hold", 128'({win1, lc1, ready1}), 128'({1'b1, 4'd1, 1'b0}));
        chk("done_hold_map", 128'(map1), 128'(pack_model()));

        do_start(lat);
        chk("restart2_lat", 128'(lat), 128'(26));
        chk("restart2_dut1", 128'({win1, lc1, ready1}), 128'({1'b0, 4'd0, 1'b1}));

        // Reset in the middle of a search (idx=10 during c11).
        @(negedge clk_25MHz);
        mark_valid = 1'b1;
        mark_num   = 5'd26;
        @(posedge clk_25MHz);
        #1 mark_valid = 1'b0;
        for (int c = 1; c <= 11; c++) @(negedge clk_25MHz);
        all_rst = 1'b1;
        @(negedge clk_25MHz);
        chk("midrst_map0", 128'(map0), 128'(0));
        chk("midrst_map1", 128'(map1), 128'(0));
        chk("midrst_outs0", 128'({ready0, done0, hit0, win0, lc0}), 128'(0));
        chk("midrst_outs1", 128'({ready1, done1, hit1, win1, lc1}), 128'(0));
        all_rst    = 1'b0;
        mark_valid = 1'b1;
        mark_num   = 5'd5;
        seen_done  = 1'b0;
        seen_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_25MHz);
            if (done0 || done1)   seen_done  = 1'b1;
            if (ready0 || ready1) seen_ready = 1'b1;
        end
        mark_valid = 1'b0;
        chk("midrst_no_done", 128'(seen_done), 128'(0));
        chk("midrst_idle_no_ready", 128'(seen_ready), 128'(0));
        chk("midrst_idle_map", 128'(map0), 128'(0));

        do_start(lat);
        chk("resume_lat", 128'(lat), 128'(26));
        chk("resume_map", 128'(map0), 128'(identity_map()));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
